// File: rtl/ogsc_seq.sv
// rtl/ogsc_seq.sv - three-stage start/select sequencer with per-stage dwell, stall, abort and op counter
module ogsc_seq #(
    parameter int STAGE_CYCLES = 1,
    parameter int OPS_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             stall,
    input  logic             abort,
    output logic [1:0]       q,
    output logic             e,
    output logic             m,
    output logic             s0,
    output logic             s1,
    output logic             s2,
    output logic             done,
    output logic             busy,
    output logic [OPS_W-1:0] ops
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ST1  = 2'b01,
        ST2  = 2'b10,
        FIN  = 2'b11
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(STAGE_CYCLES - 1);

    state_t           state;
    logic             mode_r;
    logic [3:0]       dwell;
    logic [OPS_W-1:0] ops_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mode_r <= 1'b0;
            dwell  <= 4'd0;
            ops_r  <= '0;
        end else if (abort && state != IDLE) begin
            // abort beats everything, including the FIN counter update
            state <= IDLE;
            dwell <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        dwell  <= 4'd0;
                        state  <= ST1;
                    end
                end
                ST1, ST2: begin
                    if (!stall) begin
                        if (dwell == DWELL_LAST) begin
                            dwell <= 4'd0;
                            state <= (state == ST1) ? ST2 : FIN;
                        end else begin
                            dwell <= dwell + 4'd1;
                        end
                    end
                end
                FIN: begin
                    ops_r <= ops_r + 1'b1;
                    if (start) begin
                        mode_r <= mode;
                        dwell  <= 4'd0;
                        state  <= ST1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        e    = 1'b0;
        m    = 1'b0;
        s0   = 1'b0;
        s1   = 1'b0;
        s2   = 1'b0;
        done = 1'b0;
        case (state)
            ST1: begin
                e  = ~stall;
                m  = mode_r;
                s0 = 1'b1;
            end
            ST2: begin
                e  = ~stall;
                m  = ~mode_r;
                s0 = 1'b1;
                s1 = 1'b1;
            end
            FIN: begin
                e    = 1'b1;
                m    = 1'b1;
                s0   = 1'b1;
                s1   = 1'b1;
                s2   = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign q    = state;
    assign busy = (state != IDLE);
    assign ops  = ops_r;

endmodule

// File: doc/ogsc_seq.md
# ogsc_seq

Sequencer for the three-stage start/select datapath. Owns the state register that the control decode previously took as an external `q` input. Accepts a start/mode request, steps the datapath through stage 1, stage 2 and finish with a programmable dwell per stage, and asserts `done` for one cycle. Supports stall, abort and back-to-back operations, and counts completed operations.

## Interface

Parameters:
- `STAGE_CYCLES`, default 1: dwell cycles per working stage, legal range 1..15.
- `OPS_W`, default 8: width of the completed-operation counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: operation request, sampled in IDLE and FIN.
- `mode` input 1: operation mode, latched when `start` is accepted.
- `stall` input 1: datapath not ready; freezes stage progress.
- `abort` input 1: cancel the current operation.
- `q` output 2: current state encoding (00 IDLE, 01 ST1, 10 ST2, 11 FIN).
- `e` output 1: datapath enable.
- `m` output 1: mux/mode select.
- `s0`, `s1`, `s2` output 1 each: stage selects.
- `done` output 1: one-cycle completion pulse.
- `busy` output 1: high when state is not IDLE.
- `ops` output `OPS_W`: completed-operation count.

## Operation

- State register: IDLE, ST1, ST2, FIN, encoded as for `q`. `q` is driven directly from the register.
- Internal registers:
  - `mode_r`: latched mode.
  - `dwell`: 4-bit stage counter.
  - `ops`.
- Outputs are a combinational decode of state, `mode_r` and `stall`. No X values are ever driven; don't-cares are driven 0.
  - IDLE: `e=0 m=0 s0=0 s1=0 s2=0 done=0`.
  - ST1: `e=~stall m=mode_r s0=1 s1=0 s2=0 done=0`.
  - ST2: `e=~stall m=~mode_r s0=1 s1=1 s2=0 done=0`.
  - FIN: `e=1 m=1 s0=1 s1=1 s2=1 done=1`.
- Transitions, in priority order:
  1. `abort=1` in ST1, ST2 or FIN: go to IDLE and clear `dwell`. `done` is not asserted on the following cycle. `ops` does not increment, even when aborting from FIN. `abort` in IDLE has no effect.
  2. IDLE with `start=1`: latch `mode` into `mode_r`, clear `dwell`, go to ST1.
  3. ST1/ST2 with `stall=1`: hold state and `dwell`.
  4. ST1/ST2 with `stall=0`:
     - If `dwell==STAGE_CYCLES-1`: clear `dwell` and advance (ST1 to ST2, ST2 to FIN).
     - Otherwise increment `dwell`.
  5. FIN (always exactly one cycle, `stall` ignored): increment `ops`, which wraps modulo 2^`OPS_W`. Then:
     - `start=1`: latch `mode`, go to ST1 (back-to-back operation).
     - Otherwise go to IDLE.
- `start` in ST1/ST2 is ignored; it is not queued.
- `mode` is ignored except on the accepting edge. Changing `mode` mid-operation has no effect.

## Timing

- Reset (asynchronous, `rst_n=0`): state IDLE, `mode_r=0`, `dwell=0`, `ops=0`. This gives `q=00 e=0 m=0 s0=0 s1=0 s2=0 done=0 busy=0`. Reset mid-operation discards the operation with no `done` pulse. Release is synchronous to `clk`.
- Cycle numbering: `start` accepted at edge 0 with no stall.
  - ST1 occupies cycles 1..N, where N = `STAGE_CYCLES`.
  - ST2 occupies cycles N+1..2N.
  - FIN (`done=1`) is cycle 2N+1.
  - Latency from start to done is 2N+1 cycles.
- Each stall cycle in ST1/ST2 extends latency by exactly one cycle. `e` is low during that cycle.
- Back-to-back operation: `start` held high during FIN gives ST1 on the next cycle with no IDLE gap. Throughput is one operation per 2N+1 cycles.
- `ops` updates at the edge that leaves FIN. It is visible the cycle after `done`.
- `abort` and `stall` asserted together: abort wins.

## Test plan

- Reset, then `start=1 mode=1` for one cycle, N=1:
  - `q` sequence 01, 10, 11, 00 on cycles 1–4.
  - `m` = 1, 0, 1.
  - `done=1` only on cycle 3.
  - `ops=1`.
- N=3, `mode=0`:
  - ST1 lasts 3 cycles with `m=0`; ST2 lasts 3 cycles with `m=1`.
  - `done` on cycle 7.
  - Toggling `mode` mid-operation leaves `m` unchanged.
- N=2, `stall=1` for 2 cycles in ST2:
  - `e=0` and `q` held during the stall.
  - `done` on cycle 7 instead of 5.
- Abort:
  - `abort=1` in ST1 on cycle 1: `q=00` on cycle 2, no `done`, `ops` unchanged.
  - `abort` during FIN: `ops` unchanged.
  - `start` in ST2: ignored.
- Back-to-back and wrap:
  - `start` held high continuously with `OPS_W=2`, N=1: FIN goes directly to ST1, a `done` pulse every 3 cycles.
  - `ops` reads 1, 2, 3, 0.
- Asynchronous reset pulse in mid-ST2 between clock edges:
  - Outputs go to reset values immediately.
  - No `done` pulse.
  - `ops=0`.
